dsdaccel_rowpacker: RTL and testbench

- Write-side companion of the 262-lane weight/activation RAM. Accepts a byte stream through a valid/ready handshake and packs it into 262-byte rows.
- Writes each row into the RAM through one write port, starting at a base address.
- Used by the host loader to place quantized images at rows 960-962, and weight rows for layers 1-3, without simulation-only init files.

---
 rtl/dsdaccel_rowpacker.sv | 176 +++++++++++++++++
 tb/tb_dsdaccel_rowpacker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsdaccel_rowpacker.sv
`timescale 1ns/1ps
// Purpose : packs a byte stream into LANES-byte rows and writes each row to the weight/activation RAM.
// Latency : last byte of a row accepted in cycle N -> o_WR_WE in N+1 -> o_BYTE_READY back in N+2.
// Backpr. : o_BYTE_READY is high only in FILL; a held byte stays on i_BYTE until ready returns.
//
// Ports:
//   i_CLK, i_RST_n        clock, asynchronous active-low reset
//   i_START               one-cycle job start (ignored unless idle)
//   i_BASE_ADDR, i_LEN    first RAM row of the job, total job bytes (0 allowed)
//   i_ALIGN_HI            final partial row is placed in the top lanes
//   i_BYTE/_VALID, o_BYTE_READY   input byte stream handshake
//   o_WR_ADDR/_DATA/_WE   RAM write port; lane p maps to RAM bits p*8+:8
//   o_BUSY, o_DONE        job in progress, one-cycle end-of-job pulse
//   o_CSUM                16-bit byte sum of the job
// Optional: define DSDACCEL_ROWPACK_CSUM_EN to build the checksum; otherwise o_CSUM is tied to 0.

module dsdaccel_rowpacker #(
  parameter int LANES = 262,
  parameter int AW    = 10,
  parameter int LENW  = 12
) (
  input  logic            i_CLK,
  input  logic            i_RST_n,
  input  logic            i_START,
  input  logic [AW-1:0]   i_BASE_ADDR,
  input  logic [LENW-1:0] i_LEN,
  input  logic            i_ALIGN_HI,
  input  logic [7:0]      i_BYTE,
  input  logic            i_BYTE_VALID,
  output logic            o_BYTE_READY,
  output logic [AW-1:0]   o_WR_ADDR,
  output logic [7:0]      o_WR_DATA [0:LANES-1],
  output logic            o_WR_WE,
  output logic            o_BUSY,
  output logic            o_DONE,
  output logic [15:0]     o_CSUM
);

  localparam int LW = $clog2(LANES + 1);
  localparam logic [LW-1:0]   C_LANES   = LW'(LANES);
  localparam logic [LENW-1:0] C_LANES_L = LENW'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_bytes;
  logic            r_align;
  logic [LW-1:0]   r_lane;
  logic [7:0]      r_row [0:LANES-1];
  logic            r_ready;
  logic            r_we;
  logic            r_busy;
  logic            r_done;

  logic            w_start;
  logic            w_xfer;
  logic [LW-1:0]   w_lane_nxt;
  logic [LENW-1:0] w_bytes_nxt;
  logic            w_row_end;
  logic [LENW-1:0] w_rem;

  // A short tail in high-aligned mode is right-justified so its last byte lands in the top lane.
  function automatic logic [LW-1:0] f_start_lane(input logic al, input logic [LENW-1:0] rem);
    if (al && (rem < C_LANES_L))
      return LW'(C_LANES_L - rem);
    return '0;
  endfunction

  assign w_start     = (r_state == S_IDLE) && i_START;
  // r_ready is only ever set in FILL, so it also qualifies the transfer.
  assign w_xfer      = r_ready && i_BYTE_VALID;
  assign w_lane_nxt  = r_lane + LW'(1);
  assign w_bytes_nxt = r_bytes + LENW'(1);
  assign w_row_end   = (w_lane_nxt == C_LANES) || (w_bytes_nxt == r_len);
  assign w_rem       = r_len - r_bytes;

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_bytes <= '0;
      r_align <= 1'b0;
      r_lane  <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int p = 0; p < LANES; p++) r_row[p] <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_START) begin
            r_addr  <= i_BASE_ADDR;
            r_len   <= i_LEN;
            r_align <= i_ALIGN_HI;
            r_bytes <= '0;
            r_lane  <= f_start_lane(i_ALIGN_HI, i_LEN);
            r_busy  <= 1'b1;
            for (int p = 0; p < LANES; p++) r_row[p] <= '0;
            if (i_LEN == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_row[r_lane] <= i_BYTE;
            r_lane        <= w_lane_nxt;
            r_bytes       <= w_bytes_nxt;
            if (w_row_end) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Row is on the write port this cycle; advance and wipe it so partial rows stay zero-padded.
          r_addr <= r_addr + AW'(1);
          for (int p = 0; p < LANES; p++) r_row[p] <= '0;
          if (r_bytes == r_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FILL;
            r_ready <= 1'b1;
            r_lane  <= f_start_lane(r_align, w_rem);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DSDACCEL_ROWPACK_CSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n)
      r_csum <= '0;
    else if (w_start)
      r_csum <= '0;
    else if (w_xfer)
      r_csum <= r_csum + {8'h00, i_BYTE};
  end

  assign o_CSUM = r_csum;
`else
  assign o_CSUM = '0;
`endif

  assign o_BYTE_READY = r_ready;
  assign o_WR_ADDR    = r_addr;
  assign o_WR_DATA    = r_row;
  assign o_WR_WE      = r_we;
  assign o_BUSY       = r_busy;
  assign o_DONE       = r_done;

endmodule

// File: tb/tb_dsdaccel_rowpacker.sv
`timescale 1ns/1ps
module tb_dsdaccel_rowpacker;
  localparam int LANES = 262;
  localparam int AW    = 10;
  localparam int LENW  = 12;

  logic            i_CLK;
  logic            i_RST_n;
  logic            i_START;
  logic [AW-1:0]   i_BASE_ADDR;
  logic [LENW-1:0] i_LEN;
  logic            i_ALIGN_HI;
  logic [7:0]      i_BYTE;
  logic            i_BYTE_VALID;
  logic            o_BYTE_READY;
  logic [AW-1:0]   o_WR_ADDR;
  logic [7:0]      o_WR_DATA [0:LANES-1];
  logic            o_WR_WE;
  logic            o_BUSY;
  logic            o_DONE;
  logic [15:0]     o_CSUM;

  dsdaccel_rowpacker #(.LANES(LANES), .AW(AW), .LENW(LENW)) dut (
    .i_CLK(i_CLK), .i_RST_n(i_RST_n), .i_START(i_START), .i_BASE_ADDR(i_BASE_ADDR),
    .i_LEN(i_LEN), .i_ALIGN_HI(i_ALIGN_HI), .i_BYTE(i_BYTE), .i_BYTE_VALID(i_BYTE_VALID),
    .o_BYTE_READY(o_BYTE_READY), .o_WR_ADDR(o_WR_ADDR), .o_WR_DATA(o_WR_DATA),
    .o_WR_WE(o_WR_WE), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_CSUM(o_CSUM)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic                 is_done;
    logic [AW-1:0]        addr;
    logic [LANES*8-1:0]   row;
    logic [15:0]          csum;
    logic                 zero_len;
  } exp_t;

  exp_t sq[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  int   start_n = -100;
  int   we_n    = -100;

  function automatic logic [7:0] val(input int mode, input int k);
    case (mode)
      0:       return 8'(k % 256);
      1:       return 8'((k + 1) % 256);
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [LANES*8-1:0] pack_row();
    logic [LANES*8-1:0] v;
    for (int p = 0; p < LANES; p++) v[p*8 +: 8] = o_WR_DATA[p];
    return v;
  endfunction

  // Reference: expected rows of a job (optionally truncated) and its DONE entry.
  task automatic push_job(input int base, input int len, input bit align, input int mode,
                          input int max_rows, input bit do_done);
    exp_t e;
    int k = 0;
    int r = 0;
    int rem = len;
    int st, n;
    logic [15:0] cs = '0;
    for (int i = 0; i < len; i++) cs = cs + {8'h00, val(mode, i)};
    while (rem > 0 && r < max_rows) begin
      e.is_done = 1'b0;
      e.row = '0;
      n  = (rem < LANES) ? rem : LANES;
      st = (align && rem < LANES) ? LANES - rem : 0;
      for (int i = 0; i < n; i++) begin
        e.row[(st + i)*8 +: 8] = val(mode, k);
        k++;
      end
      e.addr = AW'((base + r) % 1024);
      e.csum = '0;
      e.zero_len = 1'b0;
      sq.push_back(e);
      rem -= n;
      r++;
    end
    if (do_done) begin
      e.is_done = 1'b1;
      e.addr = '0;
      e.row = '0;
`ifdef DSDACCEL_ROWPACK_CSUM_EN
      e.csum = cs;
`else
      e.csum = '0;
`endif
      e.zero_len = (len == 0);
      sq.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  exp_t               me;
  logic [LANES*8-1:0] mgot;
  always @(negedge i_CLK) begin
    ncyc++;
    if (i_RST_n) begin
      if (i_START && !o_BUSY) start_n = ncyc;
      if (o_WR_WE) begin
        total++;
        if (sq.size() == 0 || sq[0].is_done) begin
          bad++;
          $display("FAIL unexpected_we: addr got=%0d, no row write expected", o_WR_ADDR);
          if (sq.size() != 0) void'(sq.pop_front());
        end else begin
          me = sq.pop_front();
          if (o_WR_ADDR !== me.addr) begin
            bad++;
            $display("FAIL we_addr: got=%0d want=%0d", o_WR_ADDR, me.addr);
          end
          total++;
          mgot = pack_row();
          if (mgot !== me.row) begin
            bad++;
            for (int p = 0; p < LANES; p++)
              if (mgot[p*8 +: 8] !== me.row[p*8 +: 8]) begin
                $display("FAIL we_row addr=%0d: lane %0d got=%02h want=%02h", me.addr, p,
                         mgot[p*8 +: 8], me.row[p*8 +: 8]);
                break;
              end
          end
          total++;
          if (o_BYTE_READY !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_write: got=%b want=0", o_BYTE_READY);
          end
        end
        we_n = ncyc;
      end
      if (o_DONE) begin
        total++;
        if (sq.size() == 0 || !sq[0].is_done) begin
          bad++;
          $display("FAIL unexpected_done: queue size=%0d, no DONE expected", sq.size());
          if (sq.size() != 0) void'(sq.pop_front());
        end else begin
          me = sq.pop_front();
          total++;
          if (me.zero_len) begin
            if (ncyc - start_n != 1) begin
              bad++;
              $display("FAIL done_after_start: gap got=%0d want=1", ncyc - start_n);
            end
          end else if (ncyc - we_n != 1) begin
            bad++;
            $display("FAIL done_after_we: gap got=%0d want=1", ncyc - we_n);
          end
          total++;
          if (o_CSUM !== me.csum) begin
            bad++;
            $display("FAIL done_csum: got=%04h want=%04h", o_CSUM, me.csum);
          end
          total++;
          if (o_BUSY !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_done: got=%b want=1", o_BUSY);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #2;
  endtask

  task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ready"}, 32'(o_BYTE_READY), 0);
    chk1({tag, "_we"},    32'(o_WR_WE), 0);
    chk1({tag, "_addr"},  32'(o_WR_ADDR), 0);
    chk1({tag, "_busy"},  32'(o_BUSY), 0);
    chk1({tag, "_done"},  32'(o_DONE), 0);
    chk1({tag, "_csum"},  32'(o_CSUM), 0);
    total++;
    if (pack_row() !== '0) begin
      bad++;
      $display("FAIL %s_data: row not all zero, want all lanes 0", tag);
    end
  endtask

  task automatic start_job(input int base, input int len, input bit align);
    i_BASE_ADDR = AW'(base);
    i_LEN       = LENW'(len);
    i_ALIGN_HI  = align;
    i_START     = 1'b1;
    tick();
    i_START     = 1'b0;
  endtask

  // Drives bytes 0..stop_at-1; optionally pulses a stray start while the job is busy.
  task automatic feed(input int mode, input bit tgl, input int stop_at, input int inj_at);
    int  k = 0;
    int  budget = 0;
    bit  tog = 1'b1;
    bit  xfer;
    while (k < stop_at && budget < 20000) begin
      i_BYTE       = val(mode, k);
      i_BYTE_VALID = tgl ? tog : 1'b1;
      if (k == inj_at) begin
        i_BASE_ADDR = 10'd7;
        i_LEN       = 12'd5;
        i_START     = 1'b1;
      end
      xfer = i_BYTE_VALID && o_BYTE_READY;
      tick();
      i_START = 1'b0;
      tog = !tog;
      if (xfer) k++;
      budget++;
    end
    i_BYTE_VALID = 1'b0;
    if (budget >= 20000) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: accepted=%0d want=%0d", k, stop_at);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((sq.size() != 0 || o_BUSY) && n < 3000) begin
      tick();
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d busy=%b want 0/0", nm, sq.size(), o_BUSY);
    end
    tick();
    tick();
  endtask

  task automatic run_job(input string nm, input int base, input int len, input bit align,
                         input int mode, input bit tgl, input int inj_at);
    push_job(base, len, align, mode, 1000, 1'b1);
    start_job(base, len, align);
    feed(mode, tgl, len, inj_at);
    wait_idle(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_RST_n = 1'b0; i_START = 1'b0; i_BASE_ADDR = '0; i_LEN = '0;
    i_ALIGN_HI = 1'b0; i_BYTE = '0; i_BYTE_VALID = 1'b0;
    #23;
    chk_all_zero("reset");
    tick();
    i_RST_n = 1'b1;
    tick();
    tick();

    // 784 bytes into rows 960..962, with a stray start while busy.
    run_job("img", 960, 784, 1'b0, 0, 1'b0, 400);
    // 256 bytes high-aligned: lanes 6..261, values 01..FF,00.
    run_job("al256", 768, 256, 1'b1, 1, 1'b0, -1);
    // 128 bytes high-aligned, valid toggling.
    run_job("al128", 896, 128, 1'b1, 0, 1'b1, -1);
    // Zero-length job.
    run_job("len0", 55, 0, 1'b0, 0, 1'b0, -1);
    // Address wrap 1023 -> 0.
    run_job("wrap", 1023, 524, 1'b0, 0, 1'b0, -1);
    // Checksum of 784 x 0xFF, held until the next start.
    run_job("csum", 200, 784, 1'b0, 2, 1'b0, -1);
`ifdef DSDACCEL_ROWPACK_CSUM_EN
    chk1("csum_hold", 32'(o_CSUM), 32'h0CF0);
`else
    chk1("csum_off", 32'(o_CSUM), 32'h0);
`endif

    // Reset during row 2 fill: only row 1 is written.
    push_job(100, 784, 1'b0, 0, 1, 1'b0);
    start_job(100, 784, 1'b0);
    feed(0, 1'b0, LANES + 10, -1);
    i_RST_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk1("midrst_pending", 32'(sq.size()), 0);
    repeat (3) tick();
    i_RST_n = 1'b1;
    repeat (6) tick();

    // Recovery job after reset: 5 bytes high-aligned into lanes 257..261.
    run_job("recover", 3, 5, 1'b1, 0, 1'b0, -1);

    chk1("final_pending", 32'(sq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
